serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Receiver for the 17-bit recirculating serial frame from the neighbouring parallel-load shift-register transmitter. Consumes that block's serial output directly.
- Hunts for the preamble and start bit, then captures the 5-bit payload and checks the trailer.
- Presents the last good payload with valid, error and lock flags on the TinyTapeout 8-bit user I/O.
- Frame on the wire, first bit first: 1 1 1 1 0 d0 d1 d2 d3 d4 0 1 0 1 1 1 1. Line idles high; the trailing ones of one frame serve as the preamble of the next.

Parameters:
- PREAMBLE_MIN, 4, minimum number of consecutive 1s that arms start-bit detection (legal 1..7).

Ports:
- io_in[0]  input  1  clock; every register is rising-edge triggered on this single clock.
- io_in[1]  input  1  reset, synchronous active-low (rst_n), sampled on the clock edge.
- io_in[2]  input  1  serial_in, one bit per clock, same clock as the transmitter.
- io_in[3]  input  1  enable; 0 holds the receiver idle.
- io_in[7:4]  input  4  unused, ignored.
- io_out[4:0]  output  5  data, last good payload (d0 = bit 0), held between frames.
- io_out[5]  output  1  data_valid, one-cycle pulse.
- io_out[6]  output  1  frame_err, one-cycle pulse.
- io_out[7]  output  1  locked, level.

Behaviour:
- All outputs are registered. serial_in is sampled at each rising edge.
- Reset (io_in[1]=0 at an edge):
  - state=HUNT, ones_cnt=0, bit_cnt=0, shift reg=0.
  - data=0, data_valid=0, frame_err=0, locked=0.
  - Mid-frame reset aborts silently: no err pulse.
- Enable low (no reset):
  - State forced to HUNT, ones_cnt=0, locked cleared.
  - data is held; the valid and err pulses are not generated.
- HUNT:
  - Sampled 1: ones_cnt increments, saturating at 7.
  - Sampled 0 with ones_cnt >= PREAMBLE_MIN: go to DATA, bit_cnt=0.
  - Sampled 0 with ones_cnt < PREAMBLE_MIN: ones_cnt=0, stay in HUNT, no error.
- DATA:
  - Capture 5 bits LSB-first into the shift reg (bit_cnt 0..4).
  - After the 5th bit, go to TRAIL with bit_cnt=0.
  - No checking in this state.
- TRAIL:
  - Expected bits are 0, 1, 0.
  - Any mismatch: frame_err=1 next cycle; locked=0; data unchanged.
  - After a mismatch, go to HUNT with ones_cnt = (mismatching bit==1 ? 1 : 0).
  - All three bits match: on the edge sampling the third bit, data <= shift reg.
  - data_valid=1 and locked=1 in the following cycle (latency 1 from the last trailer bit).
  - After a match, go to HUNT with ones_cnt=0.
- data_valid and frame_err are never high together. Each is high for exactly one cycle per frame.
- locked:
  - Set by a good frame.
  - Cleared by frame_err, enable low or reset.
  - A good frame following an error re-sets it.
- Back-to-back recirculating frames (period 17):
  - The 4 trailing ones re-arm HUNT exactly at PREAMBLE_MIN=4.
  - data_valid then pulses every 17 cycles.
- Continuous 0s in HUNT keep ones_cnt=0 and produce no flags.
- A continuous 1s line saturates ones_cnt and produces no flags.

Test Plan:
- Reset, enable=1, 8 idle 1s, then frame payload 0x16 (bits 0,1,1,0,1) → data_valid pulse 1 cycle after the 3rd trailer bit (9 bits after the start edge); data=0x16, locked=1.
- Continuous recirculating stream for payload 0x16 → data_valid every 17 cycles, data stays 0x16, frame_err never asserts, locked stays 1.
- Corrupt the middle trailer bit (0,0,0) after a locked frame → frame_err pulse; data stays 0x16; locked=0. Next clean frame re-locks.
- Only 3 preamble ones before a 0, followed by payload and trailer → no data_valid, no frame_err. A following 4+ ones frame decodes normally.
- Assert reset during the 3rd data bit → all outputs 0 the next cycle, no err pulse. Receiver resyncs on the next full frame.
- Drop enable for 2 cycles mid-payload → no pulses, locked=0, data held. Clean frame after enable=1 gives data_valid.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: preamble/start hunter, 5-bit LSB-first payload capture, 0-1-0 trailer check.
// Revision 1.0
`default_nettype none

module serial_frame_rx #(
   parameter int PREAMBLE_MIN = 4
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      DATA  = 2'd1,
      TRAIL = 2'd2
   } state_t;

   logic clk;
   logic rst_n;
   logic serial_w;
   logic enable_w;
   logic unused_w;

   assign clk      = io_in[0];
   assign rst_n    = io_in[1];
   assign serial_w = io_in[2];
   assign enable_w = io_in[3];
   assign unused_w = ^io_in[7:4];

   state_t     state_q;
   logic [2:0] ones_q;
   logic [2:0] bit_q;
   logic [4:0] shift_q;
   logic [4:0] data_q;
   logic       valid_q;
   logic       err_q;
   logic       locked_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         ones_q   <= 3'd0;
         bit_q    <= 3'd0;
         shift_q  <= 5'd0;
         data_q   <= 5'd0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (!enable_w) begin
            state_q  <= HUNT;
            ones_q   <= 3'd0;
            locked_q <= 1'b0;
         end else begin
            case (state_q)
               HUNT: begin
                  if (serial_w) begin
                     if (ones_q != 3'd7) ones_q <= ones_q + 3'd1;
                  end else if (ones_q >= 3'(PREAMBLE_MIN)) begin
                     state_q <= DATA;
                     bit_q   <= 3'd0;
                     ones_q  <= 3'd0;
                  end else begin
                     ones_q <= 3'd0;
                  end
               end
               DATA: begin
                  // Shift in from the top so d0 lands in bit 0 after five bits.
                  shift_q <= {serial_w, shift_q[4:1]};
                  if (bit_q == 3'd4) begin
                     state_q <= TRAIL;
                     bit_q   <= 3'd0;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
               TRAIL: begin
                  // Trailer pattern is 0,1,0: only the middle position expects a 1.
                  if (serial_w != (bit_q == 3'd1)) begin
                     err_q    <= 1'b1;
                     locked_q <= 1'b0;
                     state_q  <= HUNT;
                     ones_q   <= {2'b00, serial_w};
                  end else if (bit_q == 3'd2) begin
                     data_q   <= shift_q;
                     valid_q  <= 1'b1;
                     locked_q <= 1'b1;
                     state_q  <= HUNT;
                     ones_q   <= 3'd0;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
               default: begin
                  state_q <= HUNT;
                  ones_q  <= 3'd0;
               end
            endcase
         end
      end
   end

   assign io_out = {locked_q, err_q, valid_q, data_q};

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames with a queue-based scoreboard for valid/err pulses.
// Revision 1.0
`default_nettype none

module tb_serial_frame_rx;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sin   = 1'b1;
   logic       en    = 1'b0;
   logic [7:0] io_in;
   logic [7:0] io_out;

   assign io_in = {4'b0000, en, sin, rst_n, clk};

   always #5 clk = ~clk;

   serial_frame_rx #(.PREAMBLE_MIN(4)) dut (
      .io_in (io_in),
      .io_out(io_out)
   );

   typedef struct {
      bit         is_err;
      logic [4:0] data;
      int         at;
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         errors   = 0;
   int         cyc      = 0;
   logic [4:0] exp_data = 5'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, want);
      end
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (io_out[5] || io_out[6]) begin
         check("flags_exclusive", {31'd0, io_out[5] & io_out[6]}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'd0, io_out[6:5]}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_is_err", {31'd0, io_out[6]}, {31'd0, e.is_err});
            check("pulse_cycle", cyc, e.at);
            check("pulse_data", {27'd0, io_out[4:0]}, {27'd0, e.data});
            check("pulse_locked", {31'd0, io_out[7]}, {31'd0, !e.is_err});
         end
      end else if (sb.size() > 0 && sb[0].at < cyc) begin
         check("missed_pulse", 32'd0, 32'd1);
         void'(sb.pop_front());
      end
   end

   task automatic drive(input bit b);
      @(negedge clk);
      sin = b;
   endtask

   task automatic idle(input int n, input bit b);
      for (int i = 0; i < n; i++) drive(b);
   endtask

   // kind: 0 no pulse, 1 valid, 2 err; pidx: trailer bit whose sampling edge causes it.
   task automatic send_frame(input int npre, input logic [4:0] d, input logic [2:0] trl,
                             input int kind, input int pidx);
      exp_t e;
      idle(npre, 1'b1);
      drive(1'b0);
      for (int i = 0; i < 5; i++) drive(d[i]);
      for (int i = 0; i < 3; i++) begin
         drive(trl[i]);
         if (kind != 0 && i == pidx) begin
            e.is_err = (kind == 2);
            e.data   = (kind == 1) ? d : exp_data;
            e.at     = cyc + 1;
            sb.push_back(e);
         end
      end
      if (kind == 1) exp_data = d;
   endtask

   initial begin
      en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {24'd0, io_out}, 32'd0);
      rst_n = 1'b1;

      // First frame after 8 idle ones
      send_frame(8, 5'h16, 3'b010, 1, 2);
      idle(4, 1'b1);
      check("hold_data_16", {27'd0, io_out[4:0]}, 32'h16);
      check("locked_after_good", {31'd0, io_out[7]}, 32'd1);

      // Recirculating stream, period 17
      for (int k = 0; k < 3; k++) begin
         send_frame(4, 5'h16, 3'b010, 1, 2);
         idle(4, 1'b1);
      end
      check("locked_stream", {31'd0, io_out[7]}, 32'd1);

      // Middle trailer bit corrupted
      send_frame(4, 5'h09, 3'b000, 2, 1);
      idle(4, 1'b1);
      check("locked_after_err", {31'd0, io_out[7]}, 32'd0);
      check("data_held_after_err", {27'd0, io_out[4:0]}, 32'h16);
      send_frame(4, 5'h0D, 3'b010, 1, 2);

      // Short preamble is ignored, then a normal frame decodes
      send_frame(3, 5'h05, 3'b010, 0, 0);
      check("short_pre_data", {27'd0, io_out[4:0]}, 32'h0D);
      send_frame(5, 5'h0A, 3'b010, 1, 2);

      // Continuous zeros and continuous ones give no flags
      idle(10, 1'b0);
      idle(12, 1'b1);

      // Reset during the third data bit
      drive(1'b0);
      drive(1'b1);
      drive(1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      sin   = 1'b1;
      @(negedge clk);
      check("mid_frame_reset", {24'd0, io_out}, 32'd0);
      exp_data = 5'd0;
      rst_n = 1'b1;
      sin   = 1'b1;
      send_frame(6, 5'h13, 3'b010, 1, 2);

      // Enable low for two cycles mid-payload
      idle(4, 1'b1);
      drive(1'b0);
      drive(1'b1);
      drive(1'b1);
      @(negedge clk);
      en  = 1'b0;
      sin = 1'b0;
      @(negedge clk);
      sin = 1'b0;
      @(negedge clk);
      check("enable_low_unlock", {31'd0, io_out[7]}, 32'd0);
      check("enable_low_hold", {27'd0, io_out[4:0]}, 32'h13);
      en  = 1'b1;
      sin = 1'b0;
      drive(1'b0);
      drive(1'b1);
      drive(1'b0);
      send_frame(4, 5'h15, 3'b010, 1, 2);
      idle(3, 1'b1);
      check("final_data", {27'd0, io_out[4:0]}, 32'h15);
      check("final_locked", {31'd0, io_out[7]}, 32'd1);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
